prefetch_queue: RTL and testbench

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

---
 rtl/prefetch_queue_if.sv | 21 ++
 rtl/prefetch_queue.sv | 154 +++++++++++++++
 tb/tb_prefetch_queue.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/prefetch_queue_if.sv
// Word-fetch handshake between the prefetch queue (master) and the bus unit (slave).
interface prefetch_queue_if;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ack;
    logic [15:0] fetch_data;

    modport master (
        output fetch_req,
        output fetch_addr,
        input  fetch_ack,
        input  fetch_data
    );

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        output fetch_ack,
        output fetch_data
    );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: circular byte buffer fed by 16-bit word fetches,
// drained from the head by decode, with flush/redirect and stale-ack discard.
module prefetch_queue #(
    parameter int unsigned DEPTH = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        flush,
    input  logic [15:0] flush_ip,
    input  logic [2:0]  consume_len,
    prefetch_queue_if.master fetch,
    output logic [3:0]  q_len,
    output logic [7:0]  q0,
    output logic [7:0]  q1,
    output logic [7:0]  q2,
    output logic [15:0] ip
);

    localparam int unsigned PW = $clog2(DEPTH);
    typedef logic [PW-1:0] ptr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DROP
    } fetch_state_e;

    fetch_state_e state_q, state_d;
    logic [7:0]   mem_q [DEPTH];
    logic [7:0]   mem_d [DEPTH];
    ptr_t         head_q, head_d;
    ptr_t         tail_q, tail_d;
    logic [3:0]   len_q, len_d;
    logic [15:0]  ip_q, ip_d;
    logic [15:0]  fptr_q, fptr_d;
    logic [15:0]  addr_q, addr_d;

    logic [3:0]   take;
    logic [3:0]   len_after;
    logic [1:0]   push_n;

    function automatic ptr_t wrap_add(ptr_t p, logic [3:0] n);
        logic [4:0] s;
        s = 5'(p) + 5'(n);
        if (s >= 5'(DEPTH)) s = s - 5'(DEPTH);
        return ptr_t'(s);
    endfunction

    function automatic logic space_ok(logic [3:0] len);
        return (5'(DEPTH) - 5'(len)) >= 5'd2;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            len_q   <= '0;
            ip_q    <= '0;
            fptr_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            len_q   <= len_d;
            ip_q    <= ip_d;
            fptr_q  <= fptr_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        head_d    = head_q;
        tail_d    = tail_q;
        len_d     = len_q;
        ip_d      = ip_q;
        fptr_d    = fptr_q;
        addr_d    = addr_q;
        take      = '0;
        len_after = len_q;
        push_n    = '0;

        if (ce) begin
            if (flush) begin
                head_d = '0;
                tail_d = '0;
                len_d  = '0;
                ip_d   = flush_ip;
                fptr_d = flush_ip;
                // An unacked request keeps its old address; its data must be thrown away.
                if (state_q != ST_IDLE && !fetch.fetch_ack) state_d = ST_DROP;
                else                                       state_d = ST_IDLE;
            end else begin
                take      = ({1'b0, consume_len} > len_q) ? len_q : {1'b0, consume_len};
                head_d    = wrap_add(head_q, take);
                ip_d      = ip_q + 16'(take);
                len_after = len_q - take;

                if (state_q == ST_FETCH && fetch.fetch_ack) begin
                    if (addr_q[0]) begin
                        mem_d[tail_q] = fetch.fetch_data[15:8];
                        push_n        = 2'd1;
                    end else begin
                        mem_d[tail_q]                  = fetch.fetch_data[7:0];
                        mem_d[wrap_add(tail_q, 4'd1)]  = fetch.fetch_data[15:8];
                        push_n                         = 2'd2;
                    end
                end
                tail_d = wrap_add(tail_q, 4'(push_n));
                fptr_d = fptr_q + 16'(push_n);
                len_d  = len_after + 4'(push_n);

                // Idle raise uses the pre-edge length: it can only shrink until the ack.
                case (state_q)
                    ST_IDLE: begin
                        if (space_ok(len_q)) begin
                            state_d = ST_FETCH;
                            addr_d  = fptr_q;
                        end
                    end
                    ST_FETCH, ST_DROP: begin
                        if (fetch.fetch_ack) begin
                            if (space_ok(len_d)) begin
                                state_d = ST_FETCH;
                                addr_d  = fptr_d;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        q0 = (len_q > 4'd0) ? mem_q[head_q]                 : '0;
        q1 = (len_q > 4'd1) ? mem_q[wrap_add(head_q, 4'd1)] : '0;
        q2 = (len_q > 4'd2) ? mem_q[wrap_add(head_q, 4'd2)] : '0;
    end

    assign q_len            = len_q;
    assign ip               = ip_q;
    assign fetch.fetch_req  = (state_q != ST_IDLE);
    assign fetch.fetch_addr = addr_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// Vector-table bench for prefetch_queue with a byte-queue scoreboard for q0..q2.
module tb_prefetch_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        flush;
    logic [15:0] flush_ip;
    logic [2:0]  consume_len;
    logic [3:0]  q_len;
    logic [7:0]  q0, q1, q2;
    logic [15:0] ip;

    prefetch_queue_if bus();

    prefetch_queue #(.DEPTH(6)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce          (ce),
        .flush       (flush),
        .flush_ip    (flush_ip),
        .consume_len (consume_len),
        .fetch       (bus),
        .q_len       (q_len),
        .q0          (q0),
        .q1          (q1),
        .q2          (q2),
        .ip          (ip)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        ce;
        logic        fl;
        logic [15:0] fip;
        logic [2:0]  cons;
        logic        ack;
        logic [15:0] data;
        int unsigned push;
        logic [3:0]  len;
        logic [15:0] ipx;
        logic        req;
        logic [15:0] addr;
    } vec_t;

    vec_t       vt[$];
    logic [7:0] sb[$];

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(logic c, logic f, logic [15:0] fip, logic [2:0] cons, logic a,
                       logic [15:0] d, int unsigned p, logic [3:0] l, logic [15:0] ipx,
                       logic r, logic [15:0] ad);
        vec_t v;
        v.ce = c; v.fl = f; v.fip = fip; v.cons = cons; v.ack = a; v.data = d;
        v.push = p; v.len = l; v.ipx = ipx; v.req = r; v.addr = ad;
        vt.push_back(v);
    endtask

    task automatic chk_bytes(string tag);
        logic [7:0] e [3];
        for (int k = 0; k < 3; k++) e[k] = (k < sb.size()) ? sb[k] : 8'h00;
        chk({tag, "_q0"}, 16'(q0), 16'(e[0]));
        chk({tag, "_q1"}, 16'(q1), 16'(e[1]));
        chk({tag, "_q2"}, 16'(q2), 16'(e[2]));
    endtask

    initial begin
        reset_n        = 1'b0;
        ce             = 1'b0;
        flush          = 1'b0;
        flush_ip       = '0;
        consume_len    = '0;
        bus.fetch_ack  = 1'b0;
        bus.fetch_data = '0;

        //   ce    fl    fip       cons  ack   data     push len    ip        req   addr
        add(1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 0, 4'd0, 16'h0000, 1'b1, 16'h0000);
        add(1'b1, 1'b1, 16'h1000, 3'd0, 1'b1, 16'hFFFF, 0, 4'd0, 16'h1000, 1'b0, 16'h0000);
        add(1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 0, 4'd0, 16'h1000, 1'b1, 16'h1000);
        add(1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 16'h2211, 2, 4'd2, 16'h1000, 1'b1, 16'h1002);
        add(1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 16'h4433, 2, 4'd4, 16'h1000, 1'b1, 16'h1004);
        add(1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 16'h6655, 2, 4'd6, 16'h1000, 1'b0, 16'h0000);
        add(1'b1, 1'b0, 16'h0000, 3'd3, 1'b0, 16'h0000, 0, 4'd3, 16'h1003, 1'b0, 16'h0000);
        add(1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 0, 4'd3, 16'h1003, 1'b1, 16'h1006);
        add(1'b1, 1'b1, 16'h3000, 3'd0, 1'b0, 16'h0000, 0, 4'd0, 16'h3000, 1'b1, 16'h1006);
        add(1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 0, 4'd0, 16'h3000, 1'b1, 16'h1006);
        add(1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 0, 4'd0, 16'h3000, 1'b1, 16'h1006);
        add(1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 16'h9988, 0, 4'd0, 16'h3000, 1'b1, 16'h3000);
        add(1'b1, 1'b1, 16'h4000, 3'd0, 1'b0, 16'h0000, 0, 4'd0, 16'h4000, 1'b1, 16'h3000);
        add(1'b1, 1'b1, 16'h4100, 3'd0, 1'b0, 16'h0000, 0, 4'd0, 16'h4100, 1'b1, 16'h3000);
        add(1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 16'h7766, 0, 4'd0, 16'h4100, 1'b1, 16'h4100);
        add(1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 16'h2211, 2, 4'd2, 16'h4100, 1'b1, 16'h4102);
        add(1'b1, 1'b0, 16'h0000, 3'd5, 1'b1, 16'hDDCC, 2, 4'd2, 16'h4102, 1'b1, 16'h4104);
        add(1'b0, 1'b1, 16'h5555, 3'd3, 1'b1, 16'hEEEE, 0, 4'd2, 16'h4102, 1'b1, 16'h4104);
        add(1'b1, 1'b1, 16'h2001, 3'd0, 1'b1, 16'h1234, 0, 4'd0, 16'h2001, 1'b0, 16'h0000);
        add(1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 0, 4'd0, 16'h2001, 1'b1, 16'h2001);
        add(1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 16'hBBAA, 1, 4'd1, 16'h2001, 1'b1, 16'h2002);
        add(1'b1, 1'b0, 16'h0000, 3'd7, 1'b0, 16'h0000, 0, 4'd0, 16'h2002, 1'b1, 16'h2002);
        add(1'b1, 1'b1, 16'hFFFF, 3'd0, 1'b1, 16'h0000, 0, 4'd0, 16'hFFFF, 1'b0, 16'h0000);
        add(1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 0, 4'd0, 16'hFFFF, 1'b1, 16'hFFFF);
        add(1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 16'hAA55, 1, 4'd1, 16'hFFFF, 1'b1, 16'h0000);
        add(1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 16'hCCBB, 2, 4'd3, 16'hFFFF, 1'b1, 16'h0002);
        add(1'b1, 1'b0, 16'h0000, 3'd2, 1'b0, 16'h0000, 0, 4'd1, 16'h0001, 1'b1, 16'h0002);

        // Reset state, sampled while reset is held.
        #2;
        chk("rst_len", 16'(q_len), 16'h0000);
        chk("rst_ip",  ip, 16'h0000);
        chk("rst_req", 16'(bus.fetch_req), 16'h0000);
        chk_bytes("rst");
        #10;
        reset_n = 1'b1;

        foreach (vt[i]) begin
            ce             = vt[i].ce;
            flush          = vt[i].fl;
            flush_ip       = vt[i].fip;
            consume_len    = vt[i].cons;
            bus.fetch_ack  = vt[i].ack;
            bus.fetch_data = vt[i].data;
            @(posedge clk);
            #1;
            if (vt[i].ce) begin
                if (vt[i].fl) begin
                    sb.delete();
                end else begin
                    for (int k = 0; k < int'(vt[i].cons); k++)
                        if (sb.size() > 0) void'(sb.pop_front());
                    if (vt[i].push == 1) begin
                        sb.push_back(vt[i].data[15:8]);
                    end else if (vt[i].push == 2) begin
                        sb.push_back(vt[i].data[7:0]);
                        sb.push_back(vt[i].data[15:8]);
                    end
                end
            end
            chk($sformatf("v%0d_len", i), 16'(q_len), 16'(vt[i].len));
            chk($sformatf("v%0d_ip", i), ip, vt[i].ipx);
            chk($sformatf("v%0d_req", i), 16'(bus.fetch_req), 16'(vt[i].req));
            if (vt[i].req)
                chk($sformatf("v%0d_addr", i), bus.fetch_addr, vt[i].addr);
            chk_bytes($sformatf("v%0d", i));
        end

        ce            = 1'b0;
        flush         = 1'b0;
        consume_len   = '0;
        bus.fetch_ack = 1'b0;

        // Asynchronous reset in the middle of an outstanding request.
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_req", 16'(bus.fetch_req), 16'h0000);
        chk("arst_len", 16'(q_len), 16'h0000);
        chk("arst_ip",  ip, 16'h0000);
        chk("arst_q0",  16'(q0), 16'h0000);
        sb.delete();

        // Stray ack on the first edge after reset is ignored; the first request rises.
        #2;
        reset_n        = 1'b1;
        ce             = 1'b1;
        bus.fetch_ack  = 1'b1;
        bus.fetch_data = 16'h5A5A;
        @(posedge clk);
        #1;
        bus.fetch_ack = 1'b0;
        chk("stray_len",  16'(q_len), 16'h0000);
        chk("stray_req",  16'(bus.fetch_req), 16'h0001);
        chk("stray_addr", bus.fetch_addr, 16'h0000);
        chk("stray_q0",   16'(q0), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
